hyper_responder: RTL and testbench

HYPER_RESPONDER -- requirements
Module: hyper_responder

---
 rtl/hyper_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_hyper_responder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_responder.sv
// HyperBus RAM responder model.
// Every clk cycle with dram_cs_l low is one bus edge. The block collects a
// 6-byte command/address word, then serves either a memory read, a memory
// write, or a zero-latency configuration-register write. Output enables are
// registered, and they are also masked combinationally by chip select and
// device reset so that the bus is released in the same cycle.
module hyper_responder #(
  parameter int          ADDR_W    = 8,
  parameter int          LAT_EDGES = 22,
  parameter logic [15:0] ID0       = 16'h0C81
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dram_cs_l,
  input  logic       dram_ck,
  input  logic       dram_rst_l,
  input  logic [7:0] dram_dq_in,
  output logic [7:0] dram_dq_out,
  output logic       dram_dq_oe,
  input  logic       dram_rwds_in,
  output logic       dram_rwds_out,
  output logic       dram_rwds_oe
);

  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [15:0] LAT_LAST    = 16'(LAT_EDGES - 1);
  localparam logic [15:0] CR0_DEFAULT = 16'h8F1F;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    WR,
    RD,
    REGWR,
    DONE
  } state_t;

  // Word-organised storage; never cleared so contents survive any reset.
  logic [15:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [39:0]        ca_q, ca_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               isRead_q, isRead_d;
  logic               isReg_q, isReg_d;
  logic               regSel_q, regSel_d;
  logic               odd_q, odd_d;
  logic [15:0]        cr0_q, cr0_d;
  logic [7:0]         dqOut_q, dqOut_d;
  logic               dqOe_q, dqOe_d;
  logic               rwdsOut_q, rwdsOut_d;
  logic               rwdsOe_q, rwdsOe_d;

  logic [47:0]        caFull;
  logic [31:0]        caWide;
  logic [ADDR_W-1:0]  caAddr;
  logic [ADDR_W-1:0]  addrNext;
  logic [15:0]        regWord;
  logic [15:0]        curWord;
  logic [15:0]        nextWord;
  logic               wrHi;
  logic               wrLo;
  logic               unusedBits;

  // The sixth command byte is still on the bus when the decode happens, so
  // the full command word is the five stored bytes plus the live input.
  assign caFull   = {ca_q, dram_dq_in};
  assign caWide   = {caFull[44:16], caFull[2:0]};
  assign caAddr   = caWide[ADDR_W-1:0];
  assign addrNext = addr_q + ADDR_W'(1);

  // Register reads never advance, so both the current and the following
  // word resolve to the selected register.
  assign regWord  = regSel_q ? cr0_q : ID0;
  assign curWord  = isReg_q ? regWord : mem[addr_q];
  assign nextWord = isReg_q ? regWord : mem[addrNext];

  // Bus clock, burst type, the ignored command bits and the address bits
  // above the memory size carry no meaning for this model.
  assign unusedBits = ^{dram_ck, caFull[45], caFull[15:3], caWide};

  // Next-state and next-output decode for the whole transaction sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ca_d      = ca_q;
    addr_d    = addr_q;
    isRead_d  = isRead_q;
    isReg_d   = isReg_q;
    regSel_d  = regSel_q;
    odd_d     = odd_q;
    cr0_d     = cr0_q;
    dqOut_d   = dqOut_q;
    dqOe_d    = dqOe_q;
    rwdsOut_d = rwdsOut_q;
    rwdsOe_d  = rwdsOe_q;
    wrHi      = 1'b0;
    wrLo      = 1'b0;

    if (!dram_rst_l) begin
      state_d   = IDLE;
      cr0_d     = CR0_DEFAULT;
      odd_d     = 1'b0;
      dqOut_d   = 8'h00;
      dqOe_d    = 1'b0;
      rwdsOut_d = 1'b0;
      rwdsOe_d  = 1'b0;
    end else if (dram_cs_l) begin
      state_d   = IDLE;
      odd_d     = 1'b0;
      dqOut_d   = 8'h00;
      dqOe_d    = 1'b0;
      rwdsOut_d = 1'b0;
      rwdsOe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ca_d      = {32'h0, dram_dq_in};
          cnt_d     = 16'd1;
          state_d   = CA;
          rwdsOe_d  = 1'b1;
          rwdsOut_d = 1'b1;
        end
        CA: begin
          ca_d  = caFull[39:0];
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd5) begin
            addr_d   = caAddr;
            isRead_d = caFull[47];
            isReg_d  = caFull[46];
            regSel_d = caWide[11];
            odd_d    = 1'b0;
            cnt_d    = 16'd0;
            if (!caFull[47] && caFull[46]) begin
              state_d   = REGWR;
              rwdsOe_d  = 1'b0;
              rwdsOut_d = 1'b0;
            end else begin
              state_d   = LAT;
              rwdsOut_d = 1'b0;
            end
          end
        end
        LAT: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAT_LAST) begin
            odd_d = 1'b0;
            if (isRead_q) begin
              state_d   = RD;
              dqOe_d    = 1'b1;
              dqOut_d   = curWord[15:8];
              rwdsOe_d  = 1'b1;
              rwdsOut_d = 1'b1;
            end else begin
              state_d   = WR;
              rwdsOe_d  = 1'b0;
              rwdsOut_d = 1'b0;
            end
          end
        end
        WR: begin
          if (!odd_q) begin
            wrHi  = !dram_rwds_in;
            odd_d = 1'b1;
          end else begin
            wrLo   = !dram_rwds_in;
            odd_d  = 1'b0;
            addr_d = addrNext;
          end
        end
        RD: begin
          if (!odd_q) begin
            dqOut_d   = curWord[7:0];
            rwdsOut_d = 1'b0;
            odd_d     = 1'b1;
          end else begin
            dqOut_d   = nextWord[15:8];
            rwdsOut_d = 1'b1;
            odd_d     = 1'b0;
            if (!isReg_q) begin
              addr_d = addrNext;
            end
          end
        end
        REGWR: begin
          if (!odd_q) begin
            cr0_d[15:8] = dram_dq_in;
            odd_d       = 1'b1;
          end else begin
            cr0_d[7:0] = dram_dq_in;
            odd_d      = 1'b0;
            state_d    = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Transaction state and registered bus outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      ca_q      <= 40'd0;
      addr_q    <= '0;
      isRead_q  <= 1'b0;
      isReg_q   <= 1'b0;
      regSel_q  <= 1'b0;
      odd_q     <= 1'b0;
      cr0_q     <= CR0_DEFAULT;
      dqOut_q   <= 8'h00;
      dqOe_q    <= 1'b0;
      rwdsOut_q <= 1'b0;
      rwdsOe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ca_q      <= ca_d;
      addr_q    <= addr_d;
      isRead_q  <= isRead_d;
      isReg_q   <= isReg_d;
      regSel_q  <= regSel_d;
      odd_q     <= odd_d;
      cr0_q     <= cr0_d;
      dqOut_q   <= dqOut_d;
      dqOe_q    <= dqOe_d;
      rwdsOut_q <= rwdsOut_d;
      rwdsOe_q  <= rwdsOe_d;
    end
  end

  // Byte-lane memory writes; a masked byte leaves its lane untouched.
  always_ff @(posedge clk) begin
    if (wrHi) begin
      mem[addr_q][15:8] <= dram_dq_in;
    end
    if (wrLo) begin
      mem[addr_q][7:0] <= dram_dq_in;
    end
  end

  assign dram_dq_out   = dqOut_q;
  assign dram_rwds_out = rwdsOut_q;
  assign dram_dq_oe    = dqOe_q & ~dram_cs_l & dram_rst_l;
  assign dram_rwds_oe  = rwdsOe_q & ~dram_cs_l & dram_rst_l;

endmodule

// File: tb/tb_hyper_responder.sv
// Self-checking bench for hyper_responder: directed bus scenarios plus
// randomized write/read bursts compared against a word-array memory model.
module tb_hyper_responder;

  localparam int LAT   = 22;
  localparam int MEMW  = 256;
  localparam int MAXK  = 700;

  logic       clk;
  logic       reset;
  logic       dram_cs_l;
  logic       dram_ck;
  logic       dram_rst_l;
  logic [7:0] dram_dq_in;
  logic [7:0] dram_dq_out;
  logic       dram_dq_oe;
  logic       dram_rwds_in;
  logic       dram_rwds_out;
  logic       dram_rwds_oe;

  int passCount;
  int checkCount;

  // Stimulus bytes for the data phase and what the bus showed on each edge.
  logic [7:0] txData    [0:MAXK-1];
  logic       txMask    [0:MAXK-1];
  logic [7:0] obsDq     [0:MAXK-1];
  logic       obsDqOe   [0:MAXK-1];
  logic       obsRwds   [0:MAXK-1];
  logic       obsRwdsOe [0:MAXK-1];
  logic [7:0] postDq;
  logic       postDqOe;
  logic       postRwds;
  logic       postRwdsOe;

  // Reference model: plain word array and the configuration register.
  logic [15:0] modelMem [0:MEMW-1];
  logic [15:0] modelCr0;

  hyper_responder #(
    .ADDR_W   (8),
    .LAT_EDGES(LAT),
    .ID0      (16'h0C81)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dram_cs_l    (dram_cs_l),
    .dram_ck      (dram_ck),
    .dram_rst_l   (dram_rst_l),
    .dram_dq_in   (dram_dq_in),
    .dram_dq_out  (dram_dq_out),
    .dram_dq_oe   (dram_dq_oe),
    .dram_rwds_in (dram_rwds_in),
    .dram_rwds_out(dram_rwds_out),
    .dram_rwds_oe (dram_rwds_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A linear burst of n bytes from word 'start' with per-byte masks.
  task automatic modelWrite(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = (start + i / 2) % MEMW;
      if (!txMask[i]) begin
        if (i % 2 == 0) modelMem[w][15:8] = txData[i];
        else            modelMem[w][7:0]  = txData[i];
      end
    end
  endtask

  function automatic logic [7:0] expByte(input int start, input int i);
    logic [15:0] w;
    w = modelMem[(start + i / 2) % MEMW];
    return (i % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  // Command word for a memory access; unused and out-of-range bits are random.
  function automatic logic [47:0] makeCa(input logic rd, input int unsigned wordAddr);
    logic [31:0] a;
    logic [12:0] junk;
    logic        burst;
    a      = $urandom;
    a[7:0] = wordAddr[7:0];
    junk   = 13'($urandom);
    burst  = 1'($urandom);
    return {rd, 1'b0, burst, a[31:3], junk, a[2:0]};
  endfunction

  task automatic idleEdges(input int n);
    repeat (n) begin
      @(negedge clk);
      dram_cs_l    = 1'b1;
      dram_rst_l   = 1'b1;
      dram_dq_in   = 8'h00;
      dram_rwds_in = 1'b0;
      dram_ck      = 1'b0;
    end
  endtask

  // Drives one burst edge by edge and records the bus at every edge.
  // abortKind: 0 = chip select high, 1 = device reset low, 2 = async reset.
  task automatic applyStimulus(input logic [47:0] ca, input int lat, input int nData,
                               input int abortAt, input int abortKind);
    int total;
    total = 6 + lat + nData;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      dram_cs_l  = 1'b0;
      dram_rst_l = 1'b1;
      dram_ck    = 1'($urandom);
      if (k < 6) begin
        dram_dq_in   = ca[47 - 8 * k -: 8];
        dram_rwds_in = 1'b0;
      end else if (k < 6 + lat) begin
        dram_dq_in   = 8'($urandom);
        dram_rwds_in = 1'b0;
      end else begin
        dram_dq_in   = txData[k - 6 - lat];
        dram_rwds_in = txMask[k - 6 - lat];
      end
      if (k == abortAt && abortKind == 0) dram_cs_l = 1'b1;
      if (k == abortAt && abortKind == 1) dram_rst_l = 1'b0;
      #1;
      obsDq[k]     = dram_dq_out;
      obsDqOe[k]   = dram_dq_oe;
      obsRwds[k]   = dram_rwds_out;
      obsRwdsOe[k] = dram_rwds_oe;
      if (k == abortAt) begin
        if (abortKind == 2) begin
          #1 reset = 1'b1;
          #1;
          postDq     = dram_dq_out;
          postDqOe   = dram_dq_oe;
          postRwds   = dram_rwds_out;
          postRwdsOe = dram_rwds_oe;
        end
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    dram_cs_l    = 1'b1;
    dram_rst_l   = 1'b1;
    dram_ck      = 1'b0;
    dram_dq_in   = 8'h00;
    dram_rwds_in = 1'b0;
    modelCr0     = 16'h8F1F;
    repeat (2) @(negedge clk);
    #1;
    checkCount++;
    if ({dram_dq_out, dram_dq_oe, dram_rwds_out, dram_rwds_oe} !== 11'h000)
      $display("[TB] FAIL reset_outputs: got dq=%h dqoe=%b rwds=%b rwdsoe=%b, expected all 0",
               dram_dq_out, dram_dq_oe, dram_rwds_out, dram_rwds_oe);
    else passCount++;
    @(negedge clk);
    reset = 1'b0;
    idleEdges(2);
  endtask

  task automatic test_fill;
    for (int i = 0; i < 2 * MEMW; i++) begin
      txData[i] = 8'($urandom);
      txMask[i] = 1'b0;
    end
    modelWrite(0, 2 * MEMW);
    applyStimulus(makeCa(1'b0, 0), LAT, 2 * MEMW, -1, 0);
    idleEdges(2);
    checkCount++;
    if (obsRwdsOe[6 + LAT] !== 1'b0 || obsDqOe[6 + LAT] !== 1'b0)
      $display("[TB] FAIL write_no_drive: got rwdsoe=%b dqoe=%b, expected 0 0",
               obsRwdsOe[6 + LAT], obsDqOe[6 + LAT]);
    else passCount++;
  endtask

  task automatic test_write_read;
    logic [7:0] expData [4];
    expData = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    for (int i = 0; i < 4; i++) begin
      txData[i] = expData[i];
      txMask[i] = 1'b0;
    end
    modelWrite(3, 4);
    applyStimulus(48'h0000_0000_0003, LAT, 4, -1, 0);
    idleEdges(2);
    applyStimulus(48'h8000_0000_0003, LAT, 4, -1, 0);
    idleEdges(2);
    for (int k = 1; k < 6; k++) begin
      checkCount++;
      if ({obsRwdsOe[k], obsRwds[k]} !== 2'b11)
        $display("[TB] FAIL ca_rwds[%0d]: got oe/out=%b%b, expected 11", k, obsRwdsOe[k], obsRwds[k]);
      else passCount++;
    end
    for (int k = 6; k < 6 + LAT; k++) begin
      checkCount++;
      if ({obsRwdsOe[k], obsRwds[k], obsDqOe[k]} !== 3'b100)
        $display("[TB] FAIL lat_bus[%0d]: got rwdsoe/rwds/dqoe=%b%b%b, expected 100",
                 k, obsRwdsOe[k], obsRwds[k], obsDqOe[k]);
      else passCount++;
    end
    for (int i = 0; i < 4; i++) begin
      int k;
      k = 6 + LAT + i;
      checkCount++;
      if (obsDq[k] !== expData[i] || obsDqOe[k] !== 1'b1)
        $display("[TB] FAIL rd_byte[%0d]: got %h oe=%b, expected %h oe=1", i, obsDq[k], obsDqOe[k], expData[i]);
      else passCount++;
      checkCount++;
      if (obsRwds[k] !== ((i % 2 == 0) ? 1'b1 : 1'b0))
        $display("[TB] FAIL rd_rwds[%0d]: got %b, expected %b", i, obsRwds[k], (i % 2 == 0));
      else passCount++;
    end
  endtask

  task automatic test_byte_mask;
    txData[0] = 8'hAA; txData[1] = 8'hAA; txMask[0] = 1'b0; txMask[1] = 1'b0;
    modelWrite(5, 2);
    applyStimulus(48'h0000_0000_0005, LAT, 2, -1, 0);
    idleEdges(1);
    txData[0] = 8'h11; txData[1] = 8'h22; txMask[0] = 1'b1; txMask[1] = 1'b0;
    modelWrite(5, 2);
    applyStimulus(48'h0000_0000_0005, LAT, 2, -1, 0);
    idleEdges(1);
    applyStimulus(48'h8000_0000_0005, LAT, 2, -1, 0);
    idleEdges(1);
    checkCount++;
    if ({obsDq[6 + LAT], obsDq[7 + LAT]} !== 16'hAA22 || modelMem[5] !== 16'hAA22)
      $display("[TB] FAIL byte_mask: got %h%h, expected aa22", obsDq[6 + LAT], obsDq[7 + LAT]);
    else passCount++;
  endtask

  task automatic test_wrap;
    logic [7:0] expData [4];
    expData = '{8'h5A, 8'hA5, 8'hC3, 8'h3C};
    for (int i = 0; i < 4; i++) begin
      txData[i] = expData[i];
      txMask[i] = 1'b0;
    end
    modelWrite(255, 4);
    applyStimulus(48'h0000_001F_0007, LAT, 4, -1, 0);
    idleEdges(1);
    applyStimulus(48'h8000_001F_0007, LAT, 4, -1, 0);
    idleEdges(1);
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (obsDq[6 + LAT + i] !== expData[i])
        $display("[TB] FAIL wrap_rd[%0d]: got %h, expected %h", i, obsDq[6 + LAT + i], expData[i]);
      else passCount++;
    end
    applyStimulus(48'h8000_0000_0000, LAT, 2, -1, 0);
    idleEdges(1);
    checkCount++;
    if ({obsDq[6 + LAT], obsDq[7 + LAT]} !== 16'hC33C)
      $display("[TB] FAIL wrap_word0: got %h%h, expected c33c", obsDq[6 + LAT], obsDq[7 + LAT]);
    else passCount++;
  endtask

  task automatic test_registers;
    txData[0] = 8'h8F; txData[1] = 8'h17; txData[2] = 8'h55; txData[3] = 8'h66;
    for (int i = 0; i < 4; i++) txMask[i] = 1'($urandom);
    modelCr0 = 16'h8F17;
    applyStimulus(48'h6000_0100_0000, 0, 4, -1, 0);
    idleEdges(1);
    applyStimulus(48'hE000_0100_0000, LAT, 4, -1, 0);
    idleEdges(1);
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (obsDq[6 + LAT + i] !== ((i % 2 == 0) ? modelCr0[15:8] : modelCr0[7:0]))
        $display("[TB] FAIL cr0_rd[%0d]: got %h, expected %h", i, obsDq[6 + LAT + i],
                 (i % 2 == 0) ? modelCr0[15:8] : modelCr0[7:0]);
      else passCount++;
    end
    applyStimulus(48'hC000_0000_0000, LAT, 4, -1, 0);
    idleEdges(1);
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (obsDq[6 + LAT + i] !== ((i % 2 == 0) ? 8'h0C : 8'h81))
        $display("[TB] FAIL id0_rd[%0d]: got %h, expected %h", i, obsDq[6 + LAT + i],
                 (i % 2 == 0) ? 8'h0C : 8'h81);
      else passCount++;
    end
  endtask

  task automatic test_abort_cs;
    for (int i = 0; i < 2; i++) begin
      txData[i] = 8'($urandom);
      txMask[i] = 1'b0;
    end
    applyStimulus(48'h0000_0001_0002, LAT, 2, 10, 0);
    checkCount++;
    if (obsRwdsOe[9] !== 1'b1)
      $display("[TB] FAIL abort_pre_oe: got %b, expected 1", obsRwdsOe[9]);
    else passCount++;
    checkCount++;
    if (obsRwdsOe[10] !== 1'b0 || obsDqOe[10] !== 1'b0)
      $display("[TB] FAIL abort_same_cycle: got rwdsoe=%b dqoe=%b, expected 0 0", obsRwdsOe[10], obsDqOe[10]);
    else passCount++;
    applyStimulus(48'h8000_0001_0002, LAT, 2, -1, 0);
    idleEdges(1);
    checkCount++;
    if ({obsDq[6 + LAT], obsDq[7 + LAT]} !== modelMem[10])
      $display("[TB] FAIL abort_no_change: got %h%h, expected %h", obsDq[6 + LAT], obsDq[7 + LAT], modelMem[10]);
    else passCount++;
  endtask

  task automatic test_rst_l;
    applyStimulus(48'hE000_0100_0000, LAT, 4, 7 + LAT, 1);
    checkCount++;
    if (obsDqOe[6 + LAT] !== 1'b1)
      $display("[TB] FAIL rstl_pre_oe: got %b, expected 1", obsDqOe[6 + LAT]);
    else passCount++;
    checkCount++;
    if (obsDqOe[7 + LAT] !== 1'b0 || obsRwdsOe[7 + LAT] !== 1'b0)
      $display("[TB] FAIL rstl_enables: got dqoe=%b rwdsoe=%b, expected 0 0", obsDqOe[7 + LAT], obsRwdsOe[7 + LAT]);
    else passCount++;
    modelCr0 = 16'h8F1F;
    idleEdges(2);
    applyStimulus(48'hE000_0100_0000, LAT, 2, -1, 0);
    idleEdges(1);
    checkCount++;
    if ({obsDq[6 + LAT], obsDq[7 + LAT]} !== modelCr0)
      $display("[TB] FAIL rstl_cr0: got %h%h, expected %h", obsDq[6 + LAT], obsDq[7 + LAT], modelCr0);
    else passCount++;
  endtask

  task automatic test_async_reset;
    applyStimulus(48'h8000_0000_0003, LAT, 4, 7 + LAT, 2);
    checkCount++;
    if (obsDqOe[7 + LAT] !== 1'b1)
      $display("[TB] FAIL areset_pre_oe: got %b, expected 1", obsDqOe[7 + LAT]);
    else passCount++;
    checkCount++;
    if ({postDq, postDqOe, postRwds, postRwdsOe} !== 11'h000)
      $display("[TB] FAIL areset_outputs: got dq=%h dqoe=%b rwds=%b rwdsoe=%b, expected all 0",
               postDq, postDqOe, postRwds, postRwdsOe);
    else passCount++;
    @(negedge clk);
    reset = 1'b0;
    idleEdges(2);
    applyStimulus(48'h8000_0000_0003, LAT, 2, -1, 0);
    idleEdges(1);
    checkCount++;
    if ({obsDq[6 + LAT], obsDq[7 + LAT]} !== modelMem[3])
      $display("[TB] FAIL areset_mem_kept: got %h%h, expected %h", obsDq[6 + LAT], obsDq[7 + LAT], modelMem[3]);
    else passCount++;
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      int start;
      int n;
      int rs;
      int rn;
      start = $urandom_range(0, MEMW - 1);
      n     = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        txData[i] = 8'($urandom);
        txMask[i] = 1'($urandom);
      end
      modelWrite(start, n);
      applyStimulus(makeCa(1'b0, start), LAT, n, -1, 0);
      idleEdges(1);
      rs = (it % 2 == 0) ? start : $urandom_range(0, MEMW - 1);
      rn = $urandom_range(1, 8);
      applyStimulus(makeCa(1'b1, rs), LAT, rn, -1, 0);
      idleEdges(1);
      for (int i = 0; i < rn; i++) begin
        checkCount++;
        if (obsDq[6 + LAT + i] !== expByte(rs, i) || obsRwds[6 + LAT + i] !== ((i % 2 == 0) ? 1'b1 : 1'b0))
          $display("[TB] FAIL rand_rd[%0d.%0d]: got %h rwds=%b, expected %h rwds=%b", it, i,
                   obsDq[6 + LAT + i], obsRwds[6 + LAT + i], expByte(rs, i), (i % 2 == 0));
        else passCount++;
      end
    end
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    test_reset();
    test_fill();
    test_write_read();
    test_byte_mask();
    test_wrap();
    test_registers();
    test_abort_cs();
    test_rst_l();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
